// File: rtl/simplex_tableau_builder.sv
// Streams a simplex tableau (constraints, slacks, RHS, objective) built from latched LP data.
// Optional bound rows x_i <= UB[i] are enabled by defining SIMPLEX_BOUND_ROWS_EN.
module simplex_tableau_builder #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NCOEFMAX   = 2,
  parameter int unsigned NREQMAX    = 1,
  parameter int unsigned NRLEQMAX   = 1,
  parameter logic [DATA_WIDTH-1:0] ONE_VAL = DATA_WIDTH'(32'h3F800000),
`ifdef SIMPLEX_BOUND_ROWS_EN
  localparam int unsigned NBOUND = NCOEFMAX,
`else
  localparam int unsigned NBOUND = 0,
`endif
  localparam int unsigned NCONS = NRLEQMAX + 2 * NREQMAX + NBOUND,
  localparam int unsigned NROWS = NCONS + 1,
  localparam int unsigned NCOLS = NCOEFMAX + NCONS + 1,
  localparam int unsigned RW    = (NROWS > 1) ? $clog2(NROWS) : 1,
  localparam int unsigned CW    = (NCOLS > 1) ? $clog2(NCOLS) : 1,
  localparam int unsigned NCW   = $clog2(NCOEFMAX + 1),
  localparam int unsigned NQW   = $clog2(NREQMAX + 1),
  localparam int unsigned NLW   = $clog2(NRLEQMAX + 1)
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  start_i,
  input  logic                  max_i,
  input  logic [DATA_WIDTH-1:0] f_i    [NCOEFMAX],
  input  logic [DATA_WIDTH-1:0] aleq_i [NRLEQMAX][NCOEFMAX],
  input  logic [DATA_WIDTH-1:0] bleq_i [NRLEQMAX],
  input  logic [DATA_WIDTH-1:0] aeq_i  [NREQMAX][NCOEFMAX],
  input  logic [DATA_WIDTH-1:0] beq_i  [NREQMAX],
  input  logic [DATA_WIDTH-1:0] ub_i   [NCOEFMAX],
  input  logic [NCW-1:0]        ncoef_i,
  input  logic [NQW-1:0]        nreq_i,
  input  logic [NLW-1:0]        nrleq_i,
  output logic                  wr_valid_o,
  input  logic                  wr_ready_i,
  output logic [RW-1:0]         wr_row_o,
  output logic [CW-1:0]         wr_col_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_DONE, S_ERR} state_e;

  state_e                state_q, state_d;
  logic                  valid_q, valid_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [RW-1:0]         row_q, row_d;
  logic [CW-1:0]         col_q, col_d;
  logic [DATA_WIDTH-1:0] data_q, data_d, elem_c;
  logic                  latch_c, counts_ok_c;

  logic [DATA_WIDTH-1:0] f_q [NCOEFMAX], aleq_q [NRLEQMAX][NCOEFMAX], bleq_q [NRLEQMAX];
  logic [DATA_WIDTH-1:0] aeq_q [NREQMAX][NCOEFMAX], beq_q [NREQMAX];
  logic [DATA_WIDTH-1:0] f_s [NCOEFMAX], aleq_s [NRLEQMAX][NCOEFMAX], bleq_s [NRLEQMAX];
  logic [DATA_WIDTH-1:0] aeq_s [NREQMAX][NCOEFMAX], beq_s [NREQMAX];
  logic [NCW-1:0]        ncoef_q, ncoef_s;
  logic [NQW-1:0]        nreq_q, nreq_s;
  logic [NLW-1:0]        nrleq_q, nrleq_s;
  logic                  max_q, max_s;
`ifdef SIMPLEX_BOUND_ROWS_EN
  logic [DATA_WIDTH-1:0] ub_q [NCOEFMAX], ub_s [NCOEFMAX];
`else
  logic                  unused_ub;
  always_comb begin
    unused_ub = 1'b0;
    for (int i = 0; i < int'(NCOEFMAX); i++) unused_ub = unused_ub ^ (^ub_i[i]);
  end
`endif

  // Sign flip that never produces -0.0.
  function automatic logic [DATA_WIDTH-1:0] neg_f(input logic [DATA_WIDTH-1:0] x);
    if (x[DATA_WIDTH-2:0] == '0) return '0;
    return {~x[DATA_WIDTH-1], x[DATA_WIDTH-2:0]};
  endfunction

  assign counts_ok_c = (int'(ncoef_i) <= int'(NCOEFMAX)) && (int'(nreq_i) <= int'(NREQMAX)) &&
                       (int'(nrleq_i) <= int'(NRLEQMAX));

  // The first element is computed while still idle, so read the live inputs then.
  always_comb begin
    if (state_q == S_IDLE) begin
      f_s = f_i; aleq_s = aleq_i; bleq_s = bleq_i; aeq_s = aeq_i; beq_s = beq_i;
      ncoef_s = ncoef_i; nreq_s = nreq_i; nrleq_s = nrleq_i; max_s = max_i;
`ifdef SIMPLEX_BOUND_ROWS_EN
      ub_s = ub_i;
`endif
    end else begin
      f_s = f_q; aleq_s = aleq_q; bleq_s = bleq_q; aeq_s = aeq_q; beq_s = beq_q;
      ncoef_s = ncoef_q; nreq_s = nreq_q; nrleq_s = nrleq_q; max_s = max_q;
`ifdef SIMPLEX_BOUND_ROWS_EN
      ub_s = ub_q;
`endif
    end
  end

  // Tableau element at the next (row, col) position.
  always_comb begin
    int r, c;
    r = int'(row_d);
    c = int'(col_d);
    elem_c = '0;
    if (c >= int'(NCOEFMAX) && c < int'(NCOEFMAX + NCONS) && r == c - int'(NCOEFMAX))
      elem_c = ONE_VAL;
    for (int i = 0; i < int'(NRLEQMAX); i++) begin
      if (r == i && i < int'(nrleq_s)) begin
        if (c == int'(NCOLS) - 1) elem_c = bleq_s[i];
        for (int j = 0; j < int'(NCOEFMAX); j++)
          if (c == j && j < int'(ncoef_s)) elem_c = aleq_s[i][j];
      end
    end
    for (int i = 0; i < int'(NREQMAX); i++) begin
      if (r == int'(NRLEQMAX) + i && i < int'(nreq_s)) begin
        if (c == int'(NCOLS) - 1) elem_c = beq_s[i];
        for (int j = 0; j < int'(NCOEFMAX); j++)
          if (c == j && j < int'(ncoef_s)) elem_c = aeq_s[i][j];
      end
      if (r == int'(NRLEQMAX + NREQMAX) + i && i < int'(nreq_s)) begin
        if (c == int'(NCOLS) - 1) elem_c = neg_f(beq_s[i]);
        for (int j = 0; j < int'(NCOEFMAX); j++)
          if (c == j && j < int'(ncoef_s)) elem_c = neg_f(aeq_s[i][j]);
      end
    end
`ifdef SIMPLEX_BOUND_ROWS_EN
    for (int i = 0; i < int'(NCOEFMAX); i++) begin
      if (r == int'(NRLEQMAX + 2 * NREQMAX) + i && i < int'(ncoef_s)) begin
        if (c == int'(NCOLS) - 1) elem_c = ub_s[i];
        if (c == i) elem_c = ONE_VAL;
      end
    end
`endif
    if (r == int'(NROWS) - 1) begin
      for (int j = 0; j < int'(NCOEFMAX); j++)
        if (c == j && j < int'(ncoef_s)) elem_c = max_s ? neg_f(f_s[j]) : f_s[j];
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    row_d   = row_q;
    col_d   = col_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    latch_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (counts_ok_c) begin
            state_d = S_EMIT;
            valid_d = 1'b1;
            busy_d  = 1'b1;
            row_d   = '0;
            col_d   = '0;
            latch_c = 1'b1;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      S_EMIT: begin
        if (wr_ready_i) begin
          if (row_q == RW'(NROWS - 1) && col_q == CW'(NCOLS - 1)) begin
            state_d = S_DONE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            row_d   = '0;
            col_d   = '0;
          end else if (col_q == CW'(NCOLS - 1)) begin
            col_d = '0;
            row_d = row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign data_d = valid_d ? elem_c : '0;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      row_q   <= row_d;
      col_q   <= col_d;
      data_q  <= data_d;
    end
  end

  // Problem snapshot taken at start acceptance; only read while a build is active.
  always_ff @(posedge clk_i) begin
    if (latch_c) begin
      f_q <= f_i; aleq_q <= aleq_i; bleq_q <= bleq_i; aeq_q <= aeq_i; beq_q <= beq_i;
      ncoef_q <= ncoef_i; nreq_q <= nreq_i; nrleq_q <= nrleq_i; max_q <= max_i;
`ifdef SIMPLEX_BOUND_ROWS_EN
      ub_q <= ub_i;
`endif
    end
  end

  assign wr_valid_o = valid_q;
  assign wr_row_o   = row_q;
  assign wr_col_o   = col_q;
  assign wr_data_o  = data_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_simplex_tableau_builder.sv
// Directed bench for simplex_tableau_builder at default parameters (bound rows disabled).
module tb_simplex_tableau_builder;

  logic        clk, rstn, start, maxv, ready;
  logic [31:0] f [2], aleq [1][2], bleq [1], aeq [1][2], beq [1], ub [2];
  logic [1:0]  ncoef;
  logic [0:0]  nreq, nrleq;
  logic        valid, busy, done, err;
  logic [1:0]  row;
  logic [2:0]  col;
  logic [31:0] data;
  logic [31:0] exp_t [24];
  int          checks = 0;
  int          errors = 0;

  simplex_tableau_builder dut (
    .clk_i(clk), .rstn_i(rstn), .start_i(start), .max_i(maxv),
    .f_i(f), .aleq_i(aleq), .bleq_i(bleq), .aeq_i(aeq), .beq_i(beq), .ub_i(ub),
    .ncoef_i(ncoef), .nreq_i(nreq), .nrleq_i(nrleq),
    .wr_valid_o(valid), .wr_ready_i(ready), .wr_row_o(row), .wr_col_o(col), .wr_data_o(data),
    .busy_o(busy), .done_o(done), .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic set_base();
    f[0] = 32'h40400000; f[1] = 32'h40A00000;
    aleq[0][0] = 32'h3F800000; aleq[0][1] = 32'h40000000; bleq[0] = 32'h41000000;
    aeq[0][0] = 32'h40400000; aeq[0][1] = 32'h40000000; beq[0] = 32'h41400000;
    ub[0] = 32'h41200000; ub[1] = 32'h41200000;
    ncoef = 2'd2; nreq = 1'b1; nrleq = 1'b1; maxv = 1'b1;
  endtask

  task automatic set_exp_base();
    exp_t = '{32'h3F800000, 32'h40000000, 32'h3F800000, 32'h0, 32'h0, 32'h41000000,
              32'h40400000, 32'h40000000, 32'h0, 32'h3F800000, 32'h0, 32'h41400000,
              32'hC0400000, 32'hC0000000, 32'h0, 32'h0, 32'h3F800000, 32'hC1400000,
              32'hC0400000, 32'hC0A00000, 32'h0, 32'h0, 32'h0, 32'h0};
  endtask

  // Start a build and check every presented beat; also probes start-while-busy and start-in-done.
  task automatic run_build(input string tag, input bit toggle, input bit scramble, input int exp_done);
    int k, done_cyc, cyc;
    k = 0; done_cyc = -1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; cyc = 1;
    check({tag, " busy@1"}, 32'(busy), 32'd1);
    while (cyc <= 120) begin
      ready = toggle ? (cyc % 2 == 1) : 1'b1;
      if (scramble && cyc == 3) begin
        f[0] = 32'hDEADBEEF; aleq[0][0] = 32'h12345678; beq[0] = 32'h0;
        maxv = 1'b0; ncoef = 2'd1; start = 1'b1;
      end
      if (scramble && cyc == 4) start = 1'b0;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (valid && k < 24) begin
        check($sformatf("%s b%0d row", tag, k), 32'(row), 32'(k / 6));
        check($sformatf("%s b%0d col", tag, k), 32'(col), 32'(k % 6));
        check($sformatf("%s b%0d data", tag, k), data, exp_t[k]);
        if (ready) k++;
      end
      @(negedge clk); cyc++;
    end
    check({tag, " beats"}, 32'(k), 32'd24);
    check({tag, " done cycle"}, 32'(done_cyc), 32'(exp_done));
    start = 1'b1;
    @(negedge clk); start = 1'b0; ready = 1'b1;
    check({tag, " start in done ignored valid"}, 32'(valid), 32'd0);
    check({tag, " start in done ignored busy"}, 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; ready = 1'b1;
    set_base();
    #1;
    check("reset valid", 32'(valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset data", data, 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // Reference build, inputs disturbed mid-stream and a start while busy.
    set_exp_base();
    run_build("ref", 1'b0, 1'b1, 25);

    // Back-pressure every other cycle.
    set_base(); set_exp_base();
    run_build("stall", 1'b1, 1'b0, 48);

    // Zero operand negation and minimise objective.
    set_base(); aeq[0][1] = 32'h0; maxv = 1'b0; set_exp_base();
    exp_t[7] = 32'h0; exp_t[13] = 32'h0;
    exp_t[18] = 32'h40400000; exp_t[19] = 32'h40A00000;
    run_build("zero_min", 1'b0, 1'b0, 25);

    // Inactive columns and rows.
    set_base(); ncoef = 2'd1; nrleq = 1'b0;
    exp_t = '{32'h0, 32'h0, 32'h3F800000, 32'h0, 32'h0, 32'h0,
              32'h40400000, 32'h0, 32'h0, 32'h3F800000, 32'h0, 32'h41400000,
              32'hC0400000, 32'h0, 32'h0, 32'h0, 32'h3F800000, 32'hC1400000,
              32'hC0400000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    run_build("inactive", 1'b0, 1'b0, 25);

    // Invalid counts.
    set_base(); ncoef = 2'd3;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("err pulse", 32'(err), 32'd1);
    check("err valid", 32'(valid), 32'd0);
    check("err busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("err one cycle", 32'(err), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("err no stream", 32'({valid, busy}), 32'd0);
      @(negedge clk);
    end

    // Reset in the middle of a build.
    set_base(); set_exp_base();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    check("pre-reset row", 32'(row), 32'd1);
    check("pre-reset col", 32'(col), 32'd4);
    rstn = 1'b0; #1;
    check("midreset valid", 32'(valid), 32'd0);
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset row", 32'(row), 32'd0);
    check("midreset col", 32'(col), 32'd0);
    check("midreset data", data, 32'd0);
    @(negedge clk); rstn = 1'b1;
    for (int i = 0; i < 30; i++) begin
      check("after reset no done", 32'({done, valid}), 32'd0);
      @(negedge clk);
    end
    run_build("restart", 1'b0, 1'b0, 25);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
